// File: rtl/edge_generator.sv
// Rebuilds a rate-limited level from single-cycle rise/fall strobes; out changes one edge after a request.
// Optional pending slot enabled by defining EDGE_GENERATOR_PENDING_EN; otherwise toggles during hold are dropped.
module edge_generator #(
   parameter int MIN_HOLD = 4,
   parameter int CNT_W    = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic pos,
   input  logic neg,
   output logic out,
   output logic busy,
   output logic dropped
);

   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(MIN_HOLD - 1);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0] cnt, cnt_n;
   logic             out_n, dropped_n;
   logic             req_v, conflict, ready;

   assign req_v    = pos ^ neg;
   assign conflict = pos & neg;
   assign ready    = (cnt == '0);

`ifdef EDGE_GENERATOR_PENDING_EN
   logic pend_v, pend_v_n, pend_lvl, pend_lvl_n;
   logic tgt_v, tgt;

   always_comb begin
      out_n      = out;
      cnt_n      = cnt;
      dropped_n  = conflict;
      pend_v_n   = pend_v;
      pend_lvl_n = pend_lvl;
      tgt_v      = req_v | pend_v;
      tgt        = req_v ? pos : pend_lvl;
      if (ready) begin
         // A fresh request takes priority over whatever is parked.
         pend_v_n = 1'b0;
         if (tgt_v && (tgt != out)) begin
            out_n = tgt;
            cnt_n = HOLD_LD;
         end
      end else begin
         cnt_n = cnt - ONE;
         if (req_v) begin
            if (pos != out) begin
               pend_v_n   = 1'b1;
               pend_lvl_n = pos;
            end else begin
               pend_v_n = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_v   <= 1'b0;
         pend_lvl <= 1'b0;
      end else begin
         pend_v   <= pend_v_n;
         pend_lvl <= pend_lvl_n;
      end
   end

   assign busy = !ready | pend_v;
`else
   always_comb begin
      out_n     = out;
      cnt_n     = cnt;
      dropped_n = conflict;
      if (ready) begin
         if (req_v && (pos != out)) begin
            out_n = pos;
            cnt_n = HOLD_LD;
         end
      end else begin
         cnt_n = cnt - ONE;
         if (req_v && (pos != out))
            dropped_n = 1'b1;
      end
   end

   assign busy = !ready;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         out     <= 1'b0;
         cnt     <= '0;
         dropped <= 1'b0;
      end else begin
         out     <= out_n;
         cnt     <= cnt_n;
         dropped <= dropped_n;
      end
   end

endmodule

// File: tb/tb_edge_generator.sv
// Directed bench for edge_generator: MIN_HOLD=4 instance plus a MIN_HOLD=1 instance.
// Expected {out,busy,dropped} are queued when each step is driven and checked after the edge.
module tb_edge_generator;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic pos = 1'b0, neg = 1'b0;
   logic pos1 = 1'b0, neg1 = 1'b0;
   logic out, busy, dropped;
   logic out1, busy1, dropped1;

   int checks = 0;
   int failures = 0;

   logic [2:0] exp_q[$];
   logic [2:0] exp1_q[$];

`ifdef EDGE_GENERATOR_PENDING_EN
   localparam bit PEND = 1'b1;
`else
   localparam bit PEND = 1'b0;
`endif

   always #5 clk = ~clk;

   edge_generator #(.MIN_HOLD(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .pos(pos), .neg(neg),
      .out(out), .busy(busy), .dropped(dropped)
   );

   edge_generator #(.MIN_HOLD(1), .CNT_W(8)) dut1 (
      .clk(clk), .reset(reset), .pos(pos1), .neg(neg1),
      .out(out1), .busy(busy1), .dropped(dropped1)
   );

   // One clock on the MIN_HOLD=4 instance; expectation is the state after the edge.
   task automatic cyc(input logic p, input logic n, input logic eo, input logic eb,
                      input logic ed, input string tag);
      logic [2:0] e;
      pos = p;
      neg = n;
      exp_q.push_back({eo, eb, ed});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      assert ({out, busy, dropped} === e)
      else begin
         failures++;
         $error("FAIL %s out/busy/dropped observed=%b expected=%b", tag, {out, busy, dropped}, e);
      end
      pos = 1'b0;
      neg = 1'b0;
   endtask

   task automatic cyc1(input logic p, input logic n, input logic eo, input string tag);
      logic [2:0] e;
      pos1 = p;
      neg1 = n;
      exp1_q.push_back({eo, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      e = exp1_q.pop_front();
      checks++;
      assert ({out1, busy1, dropped1} === e)
      else begin
         failures++;
         $error("FAIL %s out/busy/dropped observed=%b expected=%b", tag, {out1, busy1, dropped1}, e);
      end
      pos1 = 1'b0;
      neg1 = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
      reset = 1'b0;
   endtask

   initial begin
      #1;
      reset = 1'b1;
      pos1  = 1'b0;
      neg1  = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_a");
      do_reset("reset_b");
      cyc1(1'b0, 1'b0, 1'b0, "m1_idle");

      // 1: single rise, busy for three cycles after the edge
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t1_idle");
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "t1_rise");
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "t1_hold2");
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "t1_hold1");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t1_ready");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t1_stable");

      // 2: fall then an immediate rise request during the hold
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "t2_fall");
      cyc(1'b1, 1'b0, 1'b0, 1'b1, !PEND, "t2_req");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t2_hold1");
      cyc(1'b0, 1'b0, 1'b0, PEND, 1'b0, "t2_cnt0");
      cyc(1'b0, 1'b0, PEND, PEND, 1'b0, "t2_apply");
      cyc(1'b0, 1'b0, PEND, PEND, 1'b0, "t2_after");
      do_reset("t2_reset");

      // 3: opposite requests during hold cancel
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "t3_rise");
      cyc(1'b0, 1'b1, 1'b1, 1'b1, !PEND, "t3_neg");
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "t3_pos");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t3_cnt0");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t3_stays");

      // 4: conflict during hold with a parked request
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "t4_fall");
      cyc(1'b1, 1'b0, 1'b0, 1'b1, !PEND, "t4_pend");
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "t4_conflict");
      cyc(1'b0, 1'b0, 1'b0, PEND, 1'b0, "t4_drop_end");
      cyc(1'b0, 1'b0, PEND, PEND, 1'b0, "t4_apply");
      do_reset("t4_reset");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "t4_conflict_ready");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t4_drop_once");

      // 5: reset mid-hold with pending, then immediate acceptance
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "t5_rise");
      cyc(1'b0, 1'b1, 1'b1, 1'b1, !PEND, "t5_pend");
      do_reset("t5_reset");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t5_no_stale");
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "t5_first");

      // 6: MIN_HOLD=1 follows alternating strobes with one cycle lag
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) cyc1(1'b1, 1'b0, 1'b1, "t6_pos");
         else            cyc1(1'b0, 1'b1, 1'b0, "t6_neg");
      end
      cyc1(1'b0, 1'b0, 1'b0, "t6_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/edge_generator.md
# edge_generator

Regenerates a clean level waveform from single-cycle rise/fall request strobes. This is the inverse of the edge detection path: a `pos` strobe drives the output high and a `neg` strobe drives it low. A programmable minimum hold time is enforced between output transitions. It sits between control logic that issues edge events and any pin or downstream block that needs a glitch-free, rate-limited level.

## Interface
- `MIN_HOLD`, 4: minimum number of cycles `out` stays at a level after a transition. Legal range is 1 to 2^`CNT_W`.
- `CNT_W`, 8: width of the hold counter.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pos`  in  1  request strobe: drive `out` high.
- `neg`  in  1  request strobe: drive `out` low.
- `out`  out  1  regenerated level, registered.
- `busy`  out  1  hold counter nonzero, or a pending request is queued.
- `dropped`  out  1  one-cycle pulse when a request is discarded.

## Operation
- State is held in four registers:
  - `out`
  - hold counter `cnt` (`CNT_W` bits)
  - `pend_v` (pending valid)
  - `pend_lvl` (pending target level)
- Ready means `cnt == 0`.
- Request decode, per cycle:
  - `pos & !neg` requests level 1.
  - `neg & !pos` requests level 0.
  - `pos & neg` is a conflict: the request is ignored and `dropped` = 1 next cycle. Existing pending state is unchanged.
- Ready cycle:
  - Effective target is the fresh request if present, else `pend_lvl` if `pend_v`. `pend_v` clears in either case.
  - If the target differs from `out`: `out` toggles at the next edge and `cnt` loads `MIN_HOLD-1`.
  - If the target equals `out`: nothing changes.
- Holding cycle (`cnt != 0`):
  - `cnt` decrements.
  - A fresh request whose target differs from `out` sets `pend_v`=1 and `pend_lvl`=target.
  - A fresh request whose target equals `out` clears `pend_v`. Opposite requests cancel, giving net no change.
  - Only one pending slot exists. A later request overwrites `pend_lvl` using the rules above, and no drop is reported.
- `busy` = (`cnt != 0`) | `pend_v`, registered-equivalent. It is derived from registered state only.
- `MIN_HOLD`=1: `cnt` always loads 0, so every valid toggling request is applied immediately and pending is never used.

## Timing
- Reset values: `out`=0, `cnt`=0, `pend_v`=0, `pend_lvl`=0, `busy`=0, `dropped`=0.
- Reset asserted mid-hold discards the count and the pending request. The first request after reset deasserts is accepted immediately.
- Latency: a request sampled at edge N in a ready cycle gives `out` changed after edge N+1. There is no combinational path from input to output.
- After a transition, `out` is stable for at least `MIN_HOLD` cycles. A pending request is applied in the cycle `cnt` reaches 0, so `out` holds exactly `MIN_HOLD` cycles when back-to-back.
- `dropped` is high for exactly one cycle per discarded request, one cycle after the request is sampled.
- Inputs are assumed synchronous to `clk`. The block has no synchronizer.

## Configuration
- `EDGE_GENERATOR_PENDING_EN` defined: pending slot present, behaviour as above.
- Not defined:
  - No pending registers.
  - Any toggling request sampled while `cnt != 0` is discarded and pulses `dropped`.
  - Same-level requests while holding are silently ignored.
  - `busy` = (`cnt != 0`).

## Test plan
1. Reset, then `pos` for 1 cycle at cycle 2 (`MIN_HOLD`=4): `out`=1 from cycle 3. `busy`=1 for cycles 3–5. No `dropped`.
2. `pos` at cycle 2, `neg` at cycle 3: with PENDING_EN, `out` is high for exactly 4 cycles then falls. Without PENDING_EN, `out` stays high and `dropped` pulses at cycle 4.
3. While holding high, `neg` then `pos` one cycle apart: pending is cancelled, `out` stays 1, and `busy` drops when `cnt` reaches 0.
4. `pos` and `neg` together at cycle 5: `dropped`=1 at cycle 6, and `out` and pending are unchanged.
5. Assert `reset` during a hold with a pending request: all outputs return to 0 the next cycle. A `pos` issued right after reset deasserts sets `out`=1 one cycle later.
6. `MIN_HOLD`=1, alternating `pos` and `neg` every cycle: `out` toggles every cycle, lagging by 1. `busy` and `dropped` stay 0.
